// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MaxReq = 16;

  // Widths depend on the instance parameters, so they are provided as functions.
  function automatic int req_idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int max_pkt_len);
    return $clog2(max_pkt_len + 1);
  endfunction

  function automatic logic [MaxReq-1:0] onehot(input logic [3:0] idx);
    logic [MaxReq-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority picker: first asserted request after last_owner, wrapping.
module fifo_rr_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_owner,
  output logic [IdxW-1:0]   pick,
  output logic              any
);

  int            idx;
  logic [IdxW-1:0] idx_t;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    idx   = 0;
    idx_t = '0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      idx_t = IdxW'(idx);
      if (!any && req[idx_t]) begin
        any  = 1'b1;
        pick = idx_t;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter for a FIFO write port, with full-flag backpressure
// and a beat limit that force-releases runaway packets and sets a sticky error.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxPktLen = 16
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr_n,
  input  logic [NumReq-1:0]           i_req_valid,
  input  logic [NumReq-1:0]           i_req_last,
  input  logic [NumReq*DataWidth-1:0] i_req_data,
  output logic [NumReq-1:0]           o_req_ready,
  input  logic                        i_full,
  output logic                        o_wr_en,
  output logic [DataWidth-1:0]        o_wr_data,
  output logic [NumReq-1:0]           o_grant,
  output logic                        o_err_overlong
);

  localparam int IdxW = req_idx_width(NumReq);
  localparam int CntW = cnt_width(MaxPktLen);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxPktLen);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic [IdxW-1:0]   pick;
  logic              any_req;
  logic              locked;
  logic              accept;
  logic              owner_last;
  logic              limit_hit;
  logic [3:0]        pick_idx4;
  logic [MaxReq-1:0] pick_oh;

  fifo_rr_pick #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_pick (
    .req       (i_req_valid),
    .last_owner(last_owner_q),
    .pick      (pick),
    .any       (any_req)
  );

  assign locked     = (state_q == LOCKED);
  assign accept     = locked & i_req_valid[owner_q] & ~i_full;
  assign owner_last = i_req_last[owner_q];
  assign limit_hit  = ((beat_cnt_q + CntOne) == CntMax);

  assign o_req_ready    = (locked & ~i_full) ? grant_q : '0;
  assign o_wr_en        = accept;
  assign o_wr_data      = locked ? i_req_data[owner_q*DataWidth +: DataWidth] : '0;
  assign o_grant        = grant_q;
  assign o_err_overlong = err_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    pick_idx4    = '0;
    pick_idx4[IdxW-1:0] = pick;
    pick_oh      = onehot(pick_idx4);

    unique case (state_q)
      IDLE: begin
        // Arbitration takes this whole cycle; no beat moves until LOCKED.
        if (any_req) begin
          state_d    = LOCKED;
          owner_d    = pick;
          grant_d    = pick_oh[NumReq-1:0];
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          if (beat_cnt_q != CntMax) beat_cnt_d = beat_cnt_q + CntOne;
          if (owner_last || limit_hit) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            err_d        = err_q | ~owner_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LastIdx;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, random run vs a reference model.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXL = 16;

  logic            clk_wr = 1'b0;
  logic            rst_wr_n;
  logic [N-1:0]    i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [N*DW-1:0] i_req_data;
  logic            i_full, o_wr_en, o_err_overlong;
  logic [DW-1:0]   o_wr_data;

  fifo_wr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxPktLen(MAXL)) dut (
    .clk_wr        (clk_wr),
    .rst_wr_n      (rst_wr_n),
    .i_req_valid   (i_req_valid),
    .i_req_last    (i_req_last),
    .i_req_data    (i_req_data),
    .o_req_ready   (o_req_ready),
    .i_full        (i_full),
    .o_wr_en       (o_wr_en),
    .o_wr_data     (o_wr_data),
    .o_grant       (o_grant),
    .o_err_overlong(o_err_overlong)
  );

  always #5 clk_wr = ~clk_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  // Reference model: owner index (-1 = nobody), previous owner, beats taken, sticky error.
  int m_owner, m_last, m_cnt;
  bit m_err;

  typedef struct {
    bit              rst;
    logic [N-1:0]    valid;
    logic [N-1:0]    last;
    logic            full;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_grant;
    logic            exp_wren;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst_wr_n    = 1'b0;
    i_req_valid = '0;
    i_req_last  = '0;
    i_req_data  = '0;
    i_full      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
  endtask

  // Compare settled combinational outputs shortly after the inputs were applied.
  task automatic expect_now(input string name, input logic [N-1:0] g, input logic w, input logic [DW-1:0] d);
    #1;
    chk({name, "_grant"}, o_grant, g);
    chk({name, "_wren"}, o_wr_en, w);
    if (w) chk({name, "_data"}, o_wr_data, d);
  endtask

  // One clock: check against the model on the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    logic [N-1:0]  eg, er;
    logic          ew;
    logic [DW-1:0] ed;
    @(negedge clk_wr);
    eg = '0; er = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg = N'(1) << m_owner;
      er = i_full ? '0 : eg;
      ew = i_req_valid[m_owner] && !i_full;
      ed = i_req_data[m_owner*DW +: DW];
    end
    chk("grant", o_grant, eg);
    chk("ready", o_req_ready, er);
    chk("wr_en", o_wr_en, ew);
    if (ew) chk("wr_data", o_wr_data, ed);
    chk("err_overlong", o_err_overlong, m_err);
    if (o_wr_en) wr_count++;

    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int r;
        r = (m_last + k) % N;
        if (i_req_valid[r]) begin
          m_owner = r;
          m_cnt   = 0;
          break;
        end
      end
    end else if (ew) begin
      m_cnt++;
      if (i_req_last[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_cnt == MAXL) begin
        m_err   = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    @(posedge clk_wr);
    #1;
  endtask

  initial begin
    // Single requester 3-beat packet, then four requesters with 1-beat packets.
    tbl[0]  = '{1, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0000, 0, 8'h00};
    tbl[1]  = '{0, 4'b0001, 4'b0000, 0, 32'h000000A1, 4'b0001, 1, 8'hA1};
    tbl[2]  = '{0, 4'b0001, 4'b0000, 0, 32'h000000A2, 4'b0001, 1, 8'hA2};
    tbl[3]  = '{0, 4'b0001, 4'b0001, 0, 32'h000000A3, 4'b0001, 1, 8'hA3};
    tbl[4]  = '{0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 0, 8'h00};
    tbl[5]  = '{1, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 8'h00};
    tbl[6]  = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 1, 8'h11};
    tbl[7]  = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 8'h00};
    tbl[8]  = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0010, 1, 8'h22};
    tbl[9]  = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 8'h00};
    tbl[10] = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0100, 1, 8'h33};
    tbl[11] = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 8'h00};
    tbl[12] = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b1000, 1, 8'h44};
    tbl[13] = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0000, 0, 8'h00};
    tbl[14] = '{0, 4'b1111, 4'b1111, 0, 32'h44332211, 4'b0001, 1, 8'h11};

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      i_req_valid = tbl[i].valid;
      i_req_last  = tbl[i].last;
      i_full      = tbl[i].full;
      i_req_data  = tbl[i].data;
      expect_now($sformatf("vec%0d", i), tbl[i].exp_grant, tbl[i].exp_wren, tbl[i].exp_data);
      cycle();
    end

    // Backpressure on requester 2 mid-packet.
    do_reset();
    i_req_valid = 4'b0100;
    i_req_data  = 32'h00CC0000;
    cycle();
    cycle();
    cycle();
    i_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_now("bp_hold", 4'b0100, 1'b0, 8'h00);
      chk("bp_ready", o_req_ready, 4'b0000);
      cycle();
    end
    i_full = 1'b0;
    expect_now("bp_resume", 4'b0100, 1'b1, 8'hCC);
    i_req_last = 4'b0100;
    cycle();
    i_req_valid = '0;
    cycle();

    // Requester 1 owns a 4-beat packet while 0 and 3 keep requesting.
    do_reset();
    i_req_valid = 4'b1011;
    i_req_last  = 4'b1001;
    i_req_data  = 32'hD000B0A0;
    cycle();
    cycle();
    cycle();
    for (int b = 0; b < 4; b++) begin
      i_req_data[15:8] = 8'hB0 + 8'(b);
      if (b == 3) i_req_last[1] = 1'b1;
      expect_now($sformatf("ni_beat%0d", b), 4'b0010, 1'b1, 8'hB0 + 8'(b));
      cycle();
    end
    expect_now("ni_idle", 4'b0000, 1'b0, 8'h00);
    cycle();
    expect_now("ni_next", 4'b1000, 1'b1, 8'hD0);
    cycle();

    // Runaway packet on requester 0 is cut after MAXL beats.
    do_reset();
    i_req_valid = 4'b0101;
    i_req_last  = 4'b0100;
    wr_count    = 0;
    for (int c = 0; c < 18; c++) begin
      i_req_data = $urandom;
      cycle();
    end
    chk("ovl_writes", wr_count, MAXL);
    chk("ovl_err", o_err_overlong, 1'b1);
    expect_now("ovl_next", 4'b0100, 1'b1, i_req_data[23:16]);
    cycle();
    i_req_valid = '0;
    repeat (3) cycle();
    chk("ovl_sticky", o_err_overlong, 1'b1);

    // Reset during the third beat of a packet.
    do_reset();
    i_req_valid = 4'b0001;
    i_req_data  = 32'h000000E0;
    cycle();
    cycle();
    cycle();
    expect_now("rst_pre", 4'b0001, 1'b1, 8'hE0);
    rst_wr_n = 1'b0;
    #1;
    chk("rst_wren", o_wr_en, 1'b0);
    chk("rst_grant", o_grant, 4'b0000);
    chk("rst_err", o_err_overlong, 1'b0);
    model_reset();
    @(posedge clk_wr);
    #1;
    rst_wr_n    = 1'b1;
    i_req_valid = 4'b1001;
    i_req_last  = 4'b1001;
    i_req_data  = 32'hF00000E1;
    cycle();
    expect_now("rst_prio", 4'b0001, 1'b1, 8'hE1);
    cycle();

    // Random traffic; second half uses rare last flags to reach the beat limit.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_req_valid = N'($urandom);
      if (c < 1500) i_req_last = N'($urandom & $urandom);
      else          i_req_last = N'($urandom & $urandom & $urandom & $urandom);
      i_full     = ($urandom_range(0, 4) == 0);
      i_req_data = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
